branch_resolve: RTL and testbench

Sequential consumer of the ALU's Zero/Neg/Cout flags in the execute stage of the pipelined processor. It holds the architectural flag register and accepts conditional-branch requests from decode through a valid/ready handshake. It evaluates the branch condition against the flags and computes the target PC. When a branch is taken, it drives a held redirect request to fetch until fetch acknowledges it. Branches are predicted not-taken, so every taken branch is a redirect, and the block counts them.

---
 rtl/branch_resolve.sv | 110 +++++++++++
 tb/tb_branch_resolve.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Execute-stage branch resolver: flag register, branch condition evaluation and held redirect to fetch.
// Optional FLAG_BYPASS_EN evaluates the condition in the acceptance cycle, so the EVAL state is never used.
module branch_resolve #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Zero,
  input  logic             Neg,
  input  logic             Cout,
  input  logic             flag_we,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_cond,
  input  logic [8:0]       br_offset,
  input  logic [15:0]      br_npc,
  output logic             redirect_valid,
  output logic [15:0]      redirect_pc,
  input  logic             redirect_ack,
  output logic [2:0]       flags,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {IDLE, EVAL, REDIRECT} state_t;

  state_t           state, state_nxt;
  logic [2:0]       flag_q;
  logic [15:0]      target_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic [15:0]      target_d;
  logic             enter_redirect;

  function automatic logic cond_met(input logic [2:0] c, input logic [2:0] f);
    logic z, n, cy;
    {z, n, cy} = f;
    case (c)
      3'b000:  return ~z;
      3'b001:  return z;
      3'b010:  return ~z & ~n;
      3'b011:  return n;
      3'b100:  return z | ~n;
      3'b101:  return z | n;
      3'b110:  return cy;
      default: return 1'b1;
    endcase
  endfunction

  assign accept         = br_valid & br_ready;
  assign target_d       = br_npc + {{6{br_offset[8]}}, br_offset, 1'b0};
  assign enter_redirect = (state_nxt == REDIRECT) && (state != REDIRECT);

`ifdef FLAG_BYPASS_EN
  // A flag write in the acceptance cycle must be visible, so forward it past the register.
  logic [2:0] byp_flags;
  assign byp_flags = flag_we ? {Zero, Neg, Cout} : flag_q;
`else
  logic [2:0] cond_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cond_q <= '0;
    else if (accept) cond_q <= br_cond;
  end
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
`ifdef FLAG_BYPASS_EN
          if (cond_met(br_cond, byp_flags)) state_nxt = REDIRECT;
`else
          state_nxt = EVAL;
`endif
        end
      end
      EVAL: begin
`ifdef FLAG_BYPASS_EN
        state_nxt = IDLE;
`else
        state_nxt = cond_met(cond_q, flag_q) ? REDIRECT : IDLE;
`endif
      end
      REDIRECT: if (redirect_ack) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      flag_q   <= '0;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state <= state_nxt;
      if (flag_we) flag_q <= {Zero, Neg, Cout};
      if (accept)  target_q <= target_d;
      if (enter_redirect && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign br_ready       = (state == IDLE);
  assign redirect_valid = (state == REDIRECT);
  assign redirect_pc    = target_q;
  assign flags          = flag_q;
  assign taken_cnt      = cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Randomized self-checking bench for branch_resolve against a behavioural model of the flag/branch rules.
// Latency expectations follow FLAG_BYPASS_EN when it is defined for the build.
module tb_branch_resolve;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             Zero = 1'b0, Neg = 1'b0, Cout = 1'b0, flag_we = 1'b0;
  logic             br_valid = 1'b0;
  logic             br_ready;
  logic [2:0]       br_cond = '0;
  logic [8:0]       br_offset = '0;
  logic [15:0]      br_npc = '0;
  logic             redirect_valid;
  logic [15:0]      redirect_pc;
  logic             redirect_ack = 1'b0;
  logic [2:0]       flags;
  logic [CNT_W-1:0] taken_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] m_flags = '0;
  int         m_cnt   = 0;

  branch_resolve #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .Zero(Zero), .Neg(Neg), .Cout(Cout), .flag_we(flag_we),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_offset(br_offset),
    .br_npc(br_npc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ack(redirect_ack), .flags(flags), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] c, input logic [2:0] f);
    bit z, n, cy;
    z = f[2]; n = f[1]; cy = f[0];
    case (int'(c))
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || !n;
      5: return z || n;
      6: return cy;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] ref_target(input logic [15:0] npc, input logic [8:0] off);
    int soff, t;
    soff = off[8] ? int'(off) - 512 : int'(off);
    t = int'(npc) + 2 * soff;
    return 16'(t);
  endfunction

  function automatic void bump_cnt();
    m_cnt = (m_cnt < (1 << CNT_W) - 1) ? m_cnt + 1 : m_cnt;
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (br_ready) return;
      @(negedge clk);
    end
    check("ready_timeout", 32'(br_ready), 32'd1);
  endtask

  task automatic write_flags(input logic [2:0] f);
    flag_we = 1'b1;
    {Zero, Neg, Cout} = f;
    @(negedge clk);
    flag_we = 1'b0;
    m_flags = f;
  endtask

  // Issue one branch from a negedge; returns at a negedge back in IDLE (or left in REDIRECT if leave=1).
  task automatic run_branch(input logic [2:0] cond, input logic [8:0] off, input logic [15:0] npc,
                            input bit we, input logic [2:0] fin, input bit ack_pre,
                            input bit ev_wr, input bit leave);
    bit         tk;
    logic [2:0] ev_f;
    wait_ready();
    br_valid = 1'b1; br_cond = cond; br_offset = off; br_npc = npc;
    flag_we = we; {Zero, Neg, Cout} = fin;
    redirect_ack = ack_pre;
    @(negedge clk);
    if (we) m_flags = fin;
    tk = ref_taken(cond, m_flags);
    br_valid = 1'b0; flag_we = 1'b0;
    br_cond = 3'($urandom); br_offset = 9'($urandom); br_npc = 16'($urandom);
`ifndef FLAG_BYPASS_EN
    check("eval_ready", 32'(br_ready), 32'd0);
    check("eval_rv", 32'(redirect_valid), 32'd0);
    ev_f = 3'($urandom);
    if (ev_wr) begin
      flag_we = 1'b1; {Zero, Neg, Cout} = ev_f;
    end
    @(negedge clk);
    if (ev_wr) begin
      flag_we = 1'b0; m_flags = ev_f;
    end
`else
    ev_f = '0;
    if (ev_wr) ev_f = '0;
`endif
    check("taken", 32'(redirect_valid), 32'(tk));
    check("ready", 32'(br_ready), 32'(!tk));
    if (tk) begin
      bump_cnt();
      check("target", 32'(redirect_pc), 32'(ref_target(npc, off)));
      check("count", 32'(taken_cnt), 32'(m_cnt));
      if (!leave) begin
        redirect_ack = 1'b1;
        @(negedge clk);
        redirect_ack = 1'b0;
        check("ack_rv", 32'(redirect_valid), 32'd0);
        check("ack_ready", 32'(br_ready), 32'd1);
      end
    end
    redirect_ack = 1'b0;
    check("flags", 32'(flags), 32'(m_flags));
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_rv", 32'(redirect_valid), 32'd0);
    check("rst_pc", 32'(redirect_pc), 32'd0);
    check("rst_cnt", 32'(taken_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(br_ready), 32'd1);

    // Condition sweep over all flag values
    for (int f = 0; f < 8; f++) begin
      write_flags(3'(f));
      for (int c = 0; c < 8; c++)
        run_branch(3'(c), 9'h004, 16'h0100, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    end

    // Negative offset and wrap-around
    run_branch(3'd7, 9'h1F8, 16'h0010, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    check("neg_off_pc", 32'(redirect_pc), 32'h0000);
    run_branch(3'd7, 9'h002, 16'hFFFE, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    check("wrap_pc", 32'(redirect_pc), 32'h0002);

    // Same-cycle flag write makes EQ taken
    write_flags(3'b000);
    run_branch(3'd1, 9'h010, 16'h0400, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0);

    // Handshake hold, then a queued branch accepted one cycle after the ack edge
    run_branch(3'd7, 9'h010, 16'h0200, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rv", 32'(redirect_valid), 32'd1);
      check("hold_pc", 32'(redirect_pc), 32'h0220);
      check("hold_ready", 32'(br_ready), 32'd0);
    end
    redirect_ack = 1'b1;
    br_valid = 1'b1; br_cond = 3'd7; br_offset = 9'h002; br_npc = 16'h0300;
    @(negedge clk);
    redirect_ack = 1'b0;
    check("q_ack_rv", 32'(redirect_valid), 32'd0);
    check("q_ack_ready", 32'(br_ready), 32'd1);
    @(negedge clk);
    br_valid = 1'b0;
`ifndef FLAG_BYPASS_EN
    check("q_eval_ready", 32'(br_ready), 32'd0);
    check("q_eval_rv", 32'(redirect_valid), 32'd0);
    @(negedge clk);
`endif
    bump_cnt();
    check("q_rv", 32'(redirect_valid), 32'd1);
    check("q_pc", 32'(redirect_pc), 32'h0304);
    check("q_cnt", 32'(taken_cnt), 32'(m_cnt));
    redirect_ack = 1'b1;
    @(negedge clk);
    redirect_ack = 1'b0;
    check("q_done_rv", 32'(redirect_valid), 32'd0);

    // Asynchronous reset while in REDIRECT
    write_flags(3'b111);
    run_branch(3'd7, 9'h020, 16'h0500, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_flags = '0; m_cnt = 0;
    check("arst_flags", 32'(flags), 32'd0);
    check("arst_rv", 32'(redirect_valid), 32'd0);
    check("arst_pc", 32'(redirect_pc), 32'd0);
    check("arst_cnt", 32'(taken_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_ready", 32'(br_ready), 32'd1);
    @(negedge clk);
    check("arst_cnt_hold", 32'(taken_cnt), 32'd0);

    // Counter saturation: 17 always-taken branches
    for (int i = 0; i < 17; i++)
      run_branch(3'd7, 9'(i), 16'(i * 64), 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    check("sat_cnt", 32'(taken_cnt), 32'hF);

    // Randomized traffic including early ack and flag writes during evaluation
    for (int i = 0; i < 150; i++)
      run_branch(3'($urandom), 9'($urandom), 16'($urandom), 1'($urandom), 3'($urandom),
                 1'($urandom), 1'($urandom), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
